// File: rtl/dct_pkg.sv
// Shared constants, cosine table and compute-FSM states for the 1-D DCT/IDCT pair.
package dct_pkg;

    localparam int COEF_W  = 12;  // signed coefficient width
    localparam int SAMP_W  = 8;   // signed sample width
    localparam int FRAC    = 12;  // fractional bits of the cosine constants
    localparam int CONST_W = 12;  // signed cosine constant width
    localparam int ACC_W   = 27;  // accumulator width, wide enough for 8 full-scale products

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_HOLD = 2'd2
    } dct_state_e;

    // COS_TAB[n][k] = round(2^FRAC * C(k)/2 * cos((2n+1)k*pi/16)), C(0) = 1/sqrt2
    localparam logic signed [CONST_W-1:0] COS_TAB [8][8] = '{
        '{12'sd1448,  12'sd2009,  12'sd1892,  12'sd1703,  12'sd1448,  12'sd1138,  12'sd784,   12'sd400},
        '{12'sd1448,  12'sd1703,  12'sd784,  -12'sd400,  -12'sd1448, -12'sd2009, -12'sd1892, -12'sd1138},
        '{12'sd1448,  12'sd1138, -12'sd784,  -12'sd2009, -12'sd1448,  12'sd400,   12'sd1892,  12'sd1703},
        '{12'sd1448,  12'sd400,  -12'sd1892, -12'sd1138,  12'sd1448,  12'sd1703, -12'sd784,  -12'sd2009},
        '{12'sd1448, -12'sd400,  -12'sd1892,  12'sd1138,  12'sd1448, -12'sd1703, -12'sd784,   12'sd2009},
        '{12'sd1448, -12'sd1138, -12'sd784,   12'sd2009, -12'sd1448, -12'sd400,   12'sd1892, -12'sd1703},
        '{12'sd1448, -12'sd1703,  12'sd784,   12'sd400,  -12'sd1448,  12'sd2009, -12'sd1892,  12'sd1138},
        '{12'sd1448, -12'sd2009,  12'sd1892, -12'sd1703,  12'sd1448, -12'sd1138,  12'sd784,  -12'sd400}
    };

    // Cosine constant for output index n and frequency index k.
    function automatic logic signed [CONST_W-1:0] cos_coef(input logic [2:0] n, input logic [2:0] k);
        return COS_TAB[n][k];
    endfunction

endpackage

// File: rtl/idct_mac.sv
// One signed multiply-accumulate step plus round-half-up and saturation of the running sum.
module idct_mac #(
    parameter int COEF_W = dct_pkg::COEF_W,
    parameter int SAMP_W = dct_pkg::SAMP_W,
    parameter int FRAC   = dct_pkg::FRAC
) (
    input  logic signed [COEF_W-1:0]          coef_in,
    input  logic signed [dct_pkg::CONST_W-1:0] cos_in,
    input  logic signed [dct_pkg::ACC_W-1:0]   acc_in,
    output logic signed [dct_pkg::ACC_W-1:0]   acc_out,
    output logic signed [SAMP_W-1:0]           samp_out
);
    import dct_pkg::*;

    localparam int PROD_W = COEF_W + CONST_W;
    localparam logic signed [ACC_W-1:0] RND_C  = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC-1);
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-SAMP_W+1){1'b0}}, {(SAMP_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-SAMP_W+1){1'b1}}, {(SAMP_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  rnd_s;
    logic signed [ACC_W-1:0]  shift_s;

    // Multiply, accumulate, then round the new sum and clamp it to the sample range.
    always_comb begin
        prod_s     = coef_in * cos_in;
        prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        acc_out    = acc_in + prod_ext_s;
        rnd_s      = acc_out + RND_C;
        shift_s    = rnd_s >>> FRAC;
        if (shift_s > SAT_HI) begin
            samp_out = SAT_HI[SAMP_W-1:0];
        end else if (shift_s < SAT_LO) begin
            samp_out = SAT_LO[SAMP_W-1:0];
        end else begin
            samp_out = shift_s[SAMP_W-1:0];
        end
    end

endmodule

// File: rtl/idct_1d.sv
// 8-point 1-D IDCT: ping-pong coefficient buffers feeding a single serial MAC,
// one sample produced every 8 cycles with a valid/ready output register.
module idct_1d #(
    parameter int COEF_W = dct_pkg::COEF_W,
    parameter int SAMP_W = dct_pkg::SAMP_W,
    parameter int FRAC   = dct_pkg::FRAC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena_in,
    output logic                     rdy_out,
    input  logic signed [COEF_W-1:0] S_in,
    output logic                     ena_out,
    input  logic                     rdy_in,
    output logic signed [SAMP_W-1:0] a_out
);
    import dct_pkg::*;

    logic signed [COEF_W-1:0]  buf_q [2][8];
    logic signed [COEF_W-1:0]  buf_d [2][8];
    logic                      fill_sel_q, fill_sel_d;   // index of the buffer being filled
    logic [3:0]                fill_cnt_q, fill_cnt_d;
    logic                      rdy_out_q, rdy_out_d;
    dct_state_e                state_q, state_d;
    logic [2:0]                n_q, n_d, k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [SAMP_W-1:0]  hold_q, hold_d;           // finished sample waiting for the output register
    logic signed [SAMP_W-1:0]  a_out_q, a_out_d;
    logic                      ena_out_q, ena_out_d;

    logic                      accept_s, out_take_s, out_free_s, fill_full_s;
    logic                      swap_s, release_s, load_s;
    logic signed [SAMP_W-1:0]  load_val_s;
    logic signed [COEF_W-1:0]  mac_coef_s;
    logic signed [CONST_W-1:0] mac_cos_s;
    logic signed [ACC_W-1:0]   mac_acc_s;
    logic signed [SAMP_W-1:0]  mac_samp_s;

    idct_mac #(
        .COEF_W (COEF_W),
        .SAMP_W (SAMP_W),
        .FRAC   (FRAC)
    ) u_mac (
        .coef_in  (mac_coef_s),
        .cos_in   (mac_cos_s),
        .acc_in   (acc_q),
        .acc_out  (mac_acc_s),
        .samp_out (mac_samp_s)
    );

    // Handshake qualifiers and MAC operand selection from the compute buffer.
    always_comb begin
        accept_s    = ena_in & rdy_out_q;
        out_take_s  = ena_out_q & rdy_in;
        out_free_s  = ~ena_out_q | rdy_in;
        fill_full_s = (fill_cnt_q == 4'd8);
        mac_coef_s  = buf_q[~fill_sel_q][k_q];
        mac_cos_s   = cos_coef(n_q, k_q);
    end

    // Compute FSM: serial MAC over k, output load or hold, row release and buffer swap.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        acc_d      = acc_q;
        hold_d     = hold_q;
        a_out_d    = a_out_q;
        ena_out_d  = out_take_s ? 1'b0 : ena_out_q;
        load_s     = 1'b0;
        load_val_s = mac_samp_s;
        release_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_full_s) begin
                    state_d = ST_MAC;
                    n_d     = 3'd0;
                    k_d     = 3'd0;
                    acc_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (k_q != 3'd7) begin
                    acc_d = mac_acc_s;
                    k_d   = k_q + 3'd1;
                end else begin
                    acc_d = '0;
                    if (out_free_s) begin
                        load_s     = 1'b1;
                        load_val_s = mac_samp_s;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = mac_samp_s;
                    end
                end
            end
            ST_HOLD: begin
                if (out_take_s) begin
                    load_s     = 1'b1;
                    load_val_s = hold_q;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            a_out_d   = load_val_s;
            ena_out_d = 1'b1;
            k_d       = 3'd0;
            if (n_q == 3'd7) begin
                release_s = 1'b1;
                n_d       = 3'd0;
                state_d   = fill_full_s ? ST_MAC : ST_IDLE;
            end else begin
                n_d     = n_q + 3'd1;
                state_d = ST_MAC;
            end
        end else begin
            a_out_d = a_out_q;
        end

        swap_s = fill_full_s & ((state_q == ST_IDLE) | release_s);
    end

    // Fill-side bookkeeping: store accepted coefficients, flip buffers on swap.
    always_comb begin
        buf_d      = buf_q;
        fill_sel_d = fill_sel_q;
        fill_cnt_d = fill_cnt_q;
        if (swap_s) begin
            fill_sel_d = ~fill_sel_q;
            if (accept_s) begin
                buf_d[~fill_sel_q][3'd0] = S_in;
                fill_cnt_d               = 4'd1;
            end else begin
                fill_cnt_d = 4'd0;
            end
        end else if (accept_s) begin
            buf_d[fill_sel_q][fill_cnt_q[2:0]] = S_in;
            fill_cnt_d                         = fill_cnt_q + 4'd1;
        end else begin
            fill_cnt_d = fill_cnt_q;
        end
        rdy_out_d = (fill_cnt_d != 4'd8);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '{default: '0};
            fill_sel_q <= 1'b0;
            fill_cnt_q <= 4'd0;
            rdy_out_q  <= 1'b0;
            state_q    <= ST_IDLE;
            n_q        <= 3'd0;
            k_q        <= 3'd0;
            acc_q      <= '0;
            hold_q     <= '0;
            a_out_q    <= '0;
            ena_out_q  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            fill_sel_q <= fill_sel_d;
            fill_cnt_q <= fill_cnt_d;
            rdy_out_q  <= rdy_out_d;
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            hold_q     <= hold_d;
            a_out_q    <= a_out_d;
            ena_out_q  <= ena_out_d;
        end
    end

    assign rdy_out = rdy_out_q;
    assign ena_out = ena_out_q;
    assign a_out   = a_out_q;

endmodule

// File: tb/tb_idct_1d.sv
// Directed self-checking bench for idct_1d: reset, latency, back-to-back rows,
// backpressure and mid-row reset, with hand-computed expected samples.
module tb_idct_1d;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena_in;
    logic               rdy_out;
    logic signed [11:0] S_in;
    logic               ena_out;
    logic               rdy_in;
    logic signed [7:0]  a_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int beats = 0;
    int last_beat_cyc = 0;
    int exp_q[$];

    // Stimulus rows (row order k=0..7) and their expected outputs (n=0..7).
    int stim [8][8] = '{
        '{200, 0, 0, 0, 0, 0, 0, 0},
        '{400, 0, 0, 0, 0, 0, 0, 0},
        '{-400, 0, 0, 0, 0, 0, 0, 0},
        '{227, -12, 3, -11, -18, -1, 0, 0},
        '{0, 100, 0, 0, 0, 0, 0, 0},
        '{100, 0, 0, 0, 0, 0, 0, 0},
        '{-200, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0}
    };
    int expv [8][8] = '{
        '{71, 71, 71, 71, 71, 71, 71, 71},
        '{127, 127, 127, 127, 127, 127, 127, 127},
        '{-128, -128, -128, -128, -128, -128, -128, -128},
        '{65, 84, 88, 74, 71, 84, 91, 86},
        '{49, 42, 28, 10, -10, -28, -42, -49},
        '{35, 35, 35, 35, 35, 35, 35, 35},
        '{-71, -71, -71, -71, -71, -71, -71, -71},
        '{0, 0, 0, 0, 0, 0, 0, 0}
    };

    idct_1d #(
        .COEF_W (12),
        .SAMP_W (8),
        .FRAC   (12)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_in  (ena_in),
        .rdy_out (rdy_out),
        .S_in    (S_in),
        .ena_out (ena_out),
        .rdy_in  (rdy_in),
        .a_out   (a_out)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: every transferring beat is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && ena_out && rdy_in) begin
            check_eq("beat_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                check_eq($sformatf("sample_%0d", beats), int'(a_out), exp_q.pop_front());
            end
            beats++;
            last_beat_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_coef(input int v);
        int   t   = 0;
        logic got = 1'b0;
        ena_in = 1'b1;
        S_in   = v[11:0];
        while (!got && t < 300) begin
            @(negedge clk);
            got = rdy_out;
            @(posedge clk);
            #1;
            t++;
        end
        ena_in = 1'b0;
        if (!got) check_eq("send_timeout", t, 0);
    endtask

    task automatic send_row(input int r);
        for (int i = 0; i < 8; i++) send_coef(stim[r][i]);
    endtask

    task automatic push_row(input int r);
        for (int i = 0; i < 8; i++) exp_q.push_back(expv[r][i]);
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    // Hard stop in case something outside the bounded waits wedges.
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int t;
        int t0;
        int b0;
        int held;

        rst_n  = 1'b0;
        ena_in = 1'b0;
        S_in   = 12'sd0;
        rdy_in = 1'b1;

        // Reset state
        tick(3);
        check_eq("rst_rdy_out", rdy_out, 0);
        check_eq("rst_ena_out", ena_out, 0);
        check_eq("rst_a_out", a_out, 0);
        rst_n = 1'b1;
        tick(1);
        check_eq("rdy_after_rst", rdy_out, 1);

        // DC row with latency: first sample 9 cycles after the 8th coefficient, then every 8
        push_row(0);
        send_row(0);
        d = 0;
        while (!ena_out && d < 40) begin
            tick(1);
            d++;
        end
        check_eq("lat_first", d, 9);
        for (int s = 1; s < 8; s++) begin
            d = 0;
            do begin
                tick(1);
                d++;
            end while (!ena_out && d < 40);
            check_eq($sformatf("lat_gap_%0d", s), d, 8);
        end
        wait_drain("drain_dc", 50);
        tick(1);
        check_eq("ena_out_idle", ena_out, 0);

        // Eight back-to-back rows, continuous output stream
        b0 = beats;
        for (int r = 0; r < 8; r++) push_row(r);
        t0 = 0;
        for (int r = 0; r < 8; r++) begin
            send_row(r);
            if (r == 0) t0 = cyc;
        end
        wait_drain("drain_b2b", 700);
        check_eq("b2b_beats", beats - b0, 64);
        check_eq("b2b_span", last_beat_cyc - t0, 513);
        tick(2);

        // Backpressure after sample 2 is presented
        b0 = beats;
        push_row(4);
        send_row(4);
        t = 0;
        while (beats < b0 + 2 && t < 200) begin
            tick(1);
            t++;
        end
        rdy_in = 1'b0;
        t = 0;
        while (!ena_out && t < 50) begin
            tick(1);
            t++;
        end
        check_eq("bp_valid", ena_out, 1);
        held = int'(a_out);
        check_eq("bp_held_value", held, 28);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_eq($sformatf("bp_ena_%0d", i), ena_out, 1);
            check_eq($sformatf("bp_hold_%0d", i), int'(a_out), held);
        end
        rdy_in = 1'b1;
        wait_drain("drain_bp", 200);
        check_eq("bp_beats", beats - b0, 8);
        tick(2);

        // Reset with a pending sample and a half-filled row
        rdy_in = 1'b0;
        send_row(1);
        for (int i = 0; i < 4; i++) send_coef(stim[3][i]);
        tick(12);
        check_eq("pre_rst_pending", ena_out, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ena_out", ena_out, 0);
        check_eq("mid_rst_a_out", a_out, 0);
        check_eq("mid_rst_rdy_out", rdy_out, 0);
        tick(1);
        rst_n = 1'b1;
        exp_q.delete();
        rdy_in = 1'b1;
        tick(1);
        check_eq("rdy_after_mid_rst", rdy_out, 1);
        b0 = beats;
        push_row(7);
        send_row(7);
        wait_drain("drain_zero", 100);
        tick(80);
        check_eq("zero_row_beats", beats - b0, 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/idct_1d.md
IDCT_1D -- requirements
Module: idct_1d

Interface
REQ-001 SHALL have parameter COEF_W, default 12, meaning signed input coefficient width.
REQ-002 SHALL have parameter SAMP_W, default 8, meaning signed output sample width.
REQ-003 SHALL have parameter FRAC, default 12, meaning fractional bits of the cosine constants.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena_in  input  1  upstream coefficient valid.
REQ-007 rdy_out  output  1  block can accept a coefficient this cycle.
REQ-008 S_in  input  COEF_W  signed coefficient; row order k=0..7.
REQ-009 ena_out  output  1  a_out valid.
REQ-010 rdy_in  input  1  downstream ready for a sample.
REQ-011 a_out  output  SAMP_W  signed reconstructed sample; row order n=0..7.

Function
REQ-012 An input beat SHALL transfer on a rising edge with ena_in=1 and rdy_out=1; an output beat SHALL transfer on a rising edge with ena_out=1 and rdy_in=1.
REQ-013 The block SHALL compute a[n] = sum over k=0..7 of c[n][k]*S[k], with c[n][k] = round(2^FRAC * C(k)/2 * cos((2n+1)k*pi/16)), C(0)=1/sqrt2, C(k>0)=1.
REQ-014 Constants SHALL be signed 12-bit; products 24-bit; accumulator SHALL be 27-bit, so no overflow for any input.
REQ-015 Each result SHALL be (acc + 2^(FRAC-1)) >>> FRAC (round half up), then saturated to [-128, 127].
REQ-016 Input storage SHALL be a ping-pong pair of 8-entry coefficient buffers: fill buffer and compute buffer.
REQ-017 rdy_out SHALL be 1 whenever the fill buffer holds fewer than 8 coefficients.
REQ-018 On the 8th accepted coefficient, buffers SHALL swap on the next edge if the compute buffer is idle; otherwise rdy_out SHALL stay 0 until the compute buffer is released.
REQ-019 The compute FSM SHALL have states IDLE, MAC, HOLD.
REQ-020 IDLE->MAC when a full row is swapped in; n=0, k=0, acc cleared.
REQ-021 In MAC, exactly one multiply-accumulate per cycle; k counts 0..7.
REQ-022 After k=7: if the output register is free, or is being drained this cycle, the rounded result SHALL load into a_out with ena_out=1, n SHALL increment and k SHALL clear; otherwise the FSM SHALL enter HOLD.
REQ-023 HOLD->MAC, loading the result, on the cycle the pending output transfers.
REQ-024 After n=7 loads, the compute buffer SHALL be released; FSM -> MAC if the next row is full, else IDLE.
REQ-025 With rdy_in held 1, the first ena_out SHALL assert 9 cycles after the 8th coefficient is accepted; the remaining samples SHALL follow one every 8 cycles.
REQ-026 While ena_out=1 and rdy_in=0, a_out SHALL hold stable and no sample SHALL be dropped or duplicated.
REQ-027 ena_out SHALL deassert the cycle after the last sample transfers, unless a new sample loads that cycle.
REQ-028 Simultaneous input accept and buffer swap SHALL not lose the coefficient; it lands in the new fill buffer.

Reset
REQ-029 While rst_n=0: ena_out=0, a_out=0, rdy_out=0, FSM=IDLE, fill counts=0, acc=0.
REQ-030 rdy_out SHALL be 1 on the first edge after rst_n deasserts.
REQ-031 Reset mid-row SHALL discard all partial input and pending output; no stale sample SHALL appear afterwards.

Structure
REQ-032 Shared package dct_pkg SHALL hold COEF_W, SAMP_W, FRAC, the 8x8 cosine constant table and the FSM state enum, shared with dct_1d.
REQ-033 One sub-module idct_mac (signed multiply, 27-bit accumulate, round, saturate) SHALL be instantiated once.

Verification
REQ-034 DC row S=[200,0,0,0,0,0,0,0] -> eight samples all equal 71.
REQ-035 Saturation: S=[400,0,...] -> all 127; S=[-400,0,...] -> all -128.
REQ-036 Round trip: feed dct_1d output for row [65,84,88,74,71,84,91,86] -> a_out within +/-1 of each input value.
REQ-037 Back-to-back: 8 rows sent with no ena_in gaps and rdy_in=1 -> 64 samples in order; rdy_out low only while both buffers are occupied.
REQ-038 Backpressure: rdy_in=0 for 20 cycles after sample n=2 -> a_out stable, ena_out=1 throughout, then samples 2..7 arrive exactly once.
REQ-039 Reset after 4 coefficients of a row -> ena_out=0; then the zero row [0,...] yields eight 0s with no stale output.
